matrix_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the matrix coprocessor's single wide memory port between several internal requesters, such as the load unit, the store unit and the tile-spill path. It sits between those requesters and the `matrix_cps_to_obi` bridge's `mem_*` port. It follows OBI address-phase rules: the selection is locked until granted, and responses are in order. It tracks outstanding transactions in an ID FIFO so each `rvalid` is routed back to the requester that issued it.

---
 rtl/matrix_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_matrix_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mem_arbiter.sv
// -----------------------------------------------------------------------------
// matrix_mem_arbiter
//
// Round-robin arbiter that lets several internal requesters of the matrix
// coprocessor share one wide OBI-style memory port. A requester that is
// presented downstream but not yet granted stays selected (address-phase
// lock) until it is granted. The index of every granted requester is pushed
// into an ID FIFO, so each in-order response is steered back to the
// requester that issued it. Grant and response paths are combinational
// pass-through, which adds no latency.
//
// Parameters
//   N_PORTS         number of requesters (>= 2)
//   BUS_WIDTH       data width in bits
//   MAX_OUTSTANDING ID FIFO depth, power of 2 (>= 1)
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i/we_i/be_i/
//   addr_i/wdata_i         per-requester address phase
//   gnt_o                  per-requester grant (one-hot or zero)
//   rvalid_o               per-requester response valid (one-hot or zero)
//   rdata_o                response data, broadcast to all requesters
//   mem_req_o/mem_we_o/
//   mem_be_o/mem_addr_o/
//   mem_wdata_o            downstream address phase
//   mem_gnt_i              downstream grant
//   mem_rvalid_i/
//   mem_rdata_i            downstream response (reads and writes)
// -----------------------------------------------------------------------------
module matrix_mem_arbiter #(
    parameter int unsigned N_PORTS         = 2,
    parameter int unsigned BUS_WIDTH       = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,

    input  logic [N_PORTS-1:0]                    req_i,
    input  logic [N_PORTS-1:0]                    we_i,
    input  logic [N_PORTS-1:0][BUS_WIDTH/8-1:0]   be_i,
    input  logic [N_PORTS-1:0][31:0]              addr_i,
    input  logic [N_PORTS-1:0][BUS_WIDTH-1:0]     wdata_i,
    output logic [N_PORTS-1:0]                    gnt_o,
    output logic [N_PORTS-1:0]                    rvalid_o,
    output logic [BUS_WIDTH-1:0]                  rdata_o,

    output logic                                  mem_req_o,
    output logic                                  mem_we_o,
    output logic [BUS_WIDTH/8-1:0]                mem_be_o,
    output logic [31:0]                           mem_addr_o,
    output logic [BUS_WIDTH-1:0]                  mem_wdata_o,
    input  logic                                  mem_gnt_i,
    input  logic                                  mem_rvalid_i,
    input  logic [BUS_WIDTH-1:0]                  mem_rdata_i
);

    localparam int unsigned IDW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned PTRW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned DEPTH = 2 ** PTRW;
    localparam int unsigned CNTW  = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } arb_state_e;

    // Arbitration state
    arb_state_e       state_q;
    logic [IDW-1:0]   lock_id_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;

    // ID FIFO
    logic [IDW-1:0]   id_mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q;
    logic [PTRW-1:0]  rd_ptr_q;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  count_d;
    logic             fifo_empty;
    logic             fifo_full;
    logic [IDW-1:0]   fifo_head;

    logic [IDW-1:0]   rr_sel;
    logic             rr_found;
    logic             lock_hold;
    logic [IDW-1:0]   sel;
    logic             handshake;
    logic             pop;

    // -------------------------------------------------------------------------
    // Selection
    // -------------------------------------------------------------------------
    always_comb begin
        rr_sel   = '0;
        rr_found = 1'b0;
        for (int unsigned off = 0; off < N_PORTS; off++) begin
            if (!rr_found && req_i[IDW'((32'(ptr_q) + off) % N_PORTS)]) begin
                rr_found = 1'b1;
                rr_sel   = IDW'((32'(ptr_q) + off) % N_PORTS);
            end
        end
    end

    // A lock whose owner has withdrawn its request is released immediately,
    // so an OBI-violating requester cannot stall the port.
    assign lock_hold = (state_q == ARB_LOCKED) && req_i[lock_id_q];
    assign sel       = lock_hold ? lock_id_q : rr_sel;

    // -------------------------------------------------------------------------
    // Downstream drive; full is registered state only, keeping mem_gnt_i and
    // mem_rvalid_i off the mem_req_o path.
    // -------------------------------------------------------------------------
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNTW'(MAX_OUTSTANDING));

    assign mem_req_o   = (|req_i) && !fifo_full;
    assign mem_we_o    = mem_req_o && we_i[sel];
    assign mem_be_o    = mem_req_o ? be_i[sel]    : '0;
    assign mem_addr_o  = mem_req_o ? addr_i[sel]  : '0;
    assign mem_wdata_o = mem_req_o ? wdata_i[sel] : '0;

    assign handshake = mem_req_o && mem_gnt_i;
    assign gnt_o     = handshake ? (N_PORTS'(1) << sel) : '0;

    assign ptr_d = (sel == IDW'(N_PORTS - 1)) ? '0 : sel + IDW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_FREE;
            lock_id_q <= '0;
            ptr_q     <= '0;
        end else if (handshake) begin
            state_q <= ARB_FREE;
            ptr_q   <= ptr_d;
        end else if (mem_req_o) begin
            state_q   <= ARB_LOCKED;
            lock_id_q <= sel;
        end else begin
            state_q <= ARB_FREE;
        end
    end

    // -------------------------------------------------------------------------
    // Response routing
    // -------------------------------------------------------------------------
    assign fifo_head = id_mem_q[rd_ptr_q];
    assign pop       = mem_rvalid_i && !fifo_empty;
    assign rvalid_o  = pop ? (N_PORTS'(1) << fifo_head) : '0;
    assign rdata_o   = mem_rdata_i;

    // -------------------------------------------------------------------------
    // ID FIFO
    // -------------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        case ({handshake, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            id_mem_q[wr_ptr_q] <= sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (handshake) begin
                wr_ptr_q <= wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTRW'(1);
            end
            count_q <= count_d;
        end
    end

    // A response with nothing outstanding is dropped; flag it in simulation.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(mem_rvalid_i && fifo_empty))
        else $warning("matrix_mem_arbiter: mem_rvalid_i with no outstanding transaction dropped");

endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for matrix_mem_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_matrix_mem_arbiter;

    localparam int N  = 2;
    localparam int BW = 32;
    localparam int MO = 4;

    logic                       clk;
    logic                       rst_n;
    logic [N-1:0]               req_s;
    logic [N-1:0]               we_s;
    logic [N-1:0][BW/8-1:0]     be_s;
    logic [N-1:0][31:0]         addr_s;
    logic [N-1:0][BW-1:0]       wdata_s;
    logic [N-1:0]               gnt_o;
    logic [N-1:0]               rvalid_o;
    logic [BW-1:0]              rdata_o;
    logic                       mem_req_o;
    logic                       mem_we_o;
    logic [BW/8-1:0]            mem_be_o;
    logic [31:0]                mem_addr_o;
    logic [BW-1:0]              mem_wdata_o;
    logic                       gnt_in;
    logic                       rvalid_in;
    logic [BW-1:0]              rdata_in;

    int checks   = 0;
    int failures = 0;

    // Reference model: outstanding requester IDs in grant order, next-priority
    // index, and the requester currently holding the address-phase lock.
    int q[$];
    int m_ptr;
    bit m_locked;
    int m_lock_id;

    int pend_sel;
    bit pend_hs;
    bit pend_pop;
    bit pend_req;

    matrix_mem_arbiter #(
        .N_PORTS         (N),
        .BUS_WIDTH       (BW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req_s),
        .we_i         (we_s),
        .be_i         (be_s),
        .addr_i       (addr_s),
        .wdata_i      (wdata_s),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (gnt_in),
        .mem_rvalid_i (rvalid_in),
        .mem_rdata_i  (rdata_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ptr     = 0;
        m_locked  = 1'b0;
        m_lock_id = 0;
    endtask

    // Settle the current inputs, then compare every DUT output with the model.
    task automatic eval();
        int            sel;
        bit            exp_req;
        logic [N-1:0]  eg;
        logic [N-1:0]  ev;
        #1;
        exp_req = (req_s != '0) && (q.size() < MO);
        sel = -1;
        if (m_locked && req_s[m_lock_id]) begin
            sel = m_lock_id;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (sel < 0 && req_s[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
            end
        end
        pend_req = exp_req;
        pend_sel = sel;
        pend_hs  = exp_req && gnt_in;
        pend_pop = rvalid_in && (q.size() > 0);
        eg = '0;
        if (pend_hs) eg[sel] = 1'b1;
        ev = '0;
        if (pend_pop) ev[q[0]] = 1'b1;

        chk("mem_req", 64'(mem_req_o), 64'(exp_req));
        chk("gnt", 64'(gnt_o), 64'(eg));
        if (exp_req) begin
            chk("mem_addr",  64'(mem_addr_o),  64'(addr_s[sel]));
            chk("mem_we",    64'(mem_we_o),    64'(we_s[sel]));
            chk("mem_be",    64'(mem_be_o),    64'(be_s[sel]));
            chk("mem_wdata", 64'(mem_wdata_o), 64'(wdata_s[sel]));
        end else begin
            chk("mem_idle", 64'({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 64'(0));
        end
        chk("rvalid", 64'(rvalid_o), 64'(ev));
        chk("rdata", 64'(rdata_o), 64'(rdata_in));
    endtask

    // Apply the clock edge to the model and move to the next cycle.
    task automatic commit();
        if (pend_pop) void'(q.pop_front());
        if (pend_hs) begin
            q.push_back(pend_sel);
            m_ptr    = (pend_sel + 1) % N;
            m_locked = 1'b0;
        end else if (pend_req) begin
            m_locked  = 1'b1;
            m_lock_id = pend_sel;
        end else begin
            m_locked = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_s     = '0;
        gnt_in    = 1'b0;
        rvalid_in = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_clear();
        #1;
        chk("rst_mem_req", 64'(mem_req_o), 64'(0));
        chk("rst_gnt", 64'(gnt_o), 64'(0));
        chk("rst_rvalid", 64'(rvalid_o), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] pat [4];
        pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10;

        rst_n = 1'b0;
        idle_inputs();
        we_s = '0; be_s = '0; addr_s = '0; wdata_s = '0; rdata_in = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rvalid_in = 1'b1;
        #1;
        chk("por_mem_req", 64'(mem_req_o), 64'(0));
        chk("por_rvalid", 64'(rvalid_o), 64'(0));
        rvalid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single read
        req_s = 2'b01; addr_s[0] = 32'h100; we_s = '0; gnt_in = 1'b1;
        eval();
        chk("t1_addr", 64'(mem_addr_o), 64'h100);
        chk("t1_gnt", 64'(gnt_o), 64'b01);
        commit();
        idle_inputs(); rvalid_in = 1'b1; rdata_in = 32'hA5;
        eval();
        chk("t1_rvalid", 64'(rvalid_o), 64'b01);
        chk("t1_rdata", 64'(rdata_o), 64'hA5);
        commit();

        // Round-robin with in-order response routing
        apply_reset();
        addr_s[0] = 32'h1000; addr_s[1] = 32'h2000;
        req_s = 2'b11; gnt_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eval();
            chk("t2_gnt", 64'(gnt_o), 64'(pat[i]));
            commit();
        end
        idle_inputs(); rvalid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rdata_in = 32'hC0 + 32'(i);
            eval();
            chk("t2_rvalid", 64'(rvalid_o), 64'(pat[i]));
            commit();
        end

        // Lock holds requester 1 across a late request from requester 0
        apply_reset();
        addr_s[0] = 32'h0000_A0A0; addr_s[1] = 32'h000B_EEF0;
        req_s = 2'b10; gnt_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) req_s = 2'b11;
            eval();
            chk("t3_addr", 64'(mem_addr_o), 64'h000B_EEF0);
            commit();
        end
        gnt_in = 1'b1;
        eval();
        chk("t3_gnt", 64'(gnt_o), 64'b10);
        commit();

        // FIFO full blocks the request even across a same-cycle pop
        apply_reset();
        req_s = 2'b01; gnt_in = 1'b1;
        repeat (4) begin eval(); commit(); end
        eval();
        chk("t4_full_req", 64'(mem_req_o), 64'(0));
        commit();
        rvalid_in = 1'b1;
        eval();
        chk("t4_pop_req", 64'(mem_req_o), 64'(0));
        chk("t4_pop_rvalid", 64'(rvalid_o), 64'b01);
        commit();
        rvalid_in = 1'b0;
        eval();
        chk("t4_resume_req", 64'(mem_req_o), 64'(1));
        commit();

        // Spurious response is dropped and does not disturb the count
        apply_reset();
        rvalid_in = 1'b1; rdata_in = 32'h55;
        eval();
        chk("t5_rvalid", 64'(rvalid_o), 64'(0));
        commit();
        rvalid_in = 1'b0; req_s = 2'b01; gnt_in = 1'b1;
        repeat (4) begin eval(); commit(); end
        eval();
        chk("t5_count_full", 64'(mem_req_o), 64'(0));
        commit();

        // Mid-flight reset with two outstanding and a lock active
        apply_reset();
        req_s = 2'b01; gnt_in = 1'b1;
        repeat (2) begin eval(); commit(); end
        req_s = 2'b10; gnt_in = 1'b0;
        eval(); commit();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req_held", 64'(mem_req_o), 64'(1));
        model_clear();
        idle_inputs();
        #1;
        chk("t6_rst_outputs", 64'({mem_req_o, gnt_o, rvalid_o}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        req_s = 2'b11; gnt_in = 1'b1;
        eval();
        chk("t6_first_gnt", 64'(gnt_o), 64'b01);
        commit();
        idle_inputs(); rvalid_in = 1'b1;
        eval();
        chk("t6_rvalid_new", 64'(rvalid_o), 64'b01);
        commit();
        eval();
        chk("t6_rvalid_empty", 64'(rvalid_o), 64'(0));
        commit();

        // Randomized traffic
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) apply_reset();
            req_s  = N'($urandom);
            we_s   = N'($urandom);
            for (int p = 0; p < N; p++) begin
                be_s[p]    = (BW/8)'($urandom);
                addr_s[p]  = $urandom;
                wdata_s[p] = BW'($urandom);
            end
            gnt_in    = ($urandom_range(0, 3) != 0);
            rvalid_in = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            rdata_in  = BW'($urandom);
            eval();
            commit();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
